// File: rtl/vend_next_state.sv
// Next-state and datapath logic for a nickel vending controller.
// State lives in an external memory: CS is last cycle's NS, returned by that memory.
module vend_next_state (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] CS,
  input  logic [1:0] COIN,
  input  logic [1:0] SEL,
  input  logic       SEL_V,
  input  logic       CANCEL,
  output logic [3:0] NS,
  output logic [5:0] CREDIT,
  output logic [1:0] PROD,
  output logic       DISPENSE,
  output logic       CHANGE_OUT,
  output logic       COIN_REJ,
  output logic       DENY
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0000,
    S_COLLECT = 4'b0001,
    S_VEND    = 4'b0010,
    S_CHANGE  = 4'b0011
  } state_e;

  localparam logic [6:0] CREDIT_MAX = 7'd40;

  function automatic logic [5:0] coin_value(input logic [1:0] c);
    case (c)
      2'b01:   coin_value = 6'd1;
      2'b10:   coin_value = 6'd2;
      2'b11:   coin_value = 6'd5;
      default: coin_value = 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] price(input logic [1:0] s);
    case (s)
      2'b00:   price = 6'd5;
      2'b01:   price = 6'd10;
      2'b10:   price = 6'd15;
      default: price = 6'd20;
    endcase
  endfunction

  state_e     ns_d, hold_s;
  logic [5:0] credit_q, credit_d;
  logic [1:0] prod_q, prod_d;
  logic [1:0] timer_q, timer_d;
  logic       coin_rej_q, coin_rej_d;
  logic       deny_q, deny_d;
  logic [6:0] coin_sum;
  logic [5:0] sel_price;
  logic       coin_present;

  assign coin_present = (COIN != 2'b00);
  assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_value(COIN)};
  assign sel_price    = price(SEL);
  // Rejected coins and refused selects leave the state where it was.
  assign hold_s       = (CS == S_COLLECT) ? S_COLLECT : S_IDLE;

  always_comb begin
    ns_d       = S_IDLE;
    credit_d   = credit_q;
    prod_d     = prod_q;
    timer_d    = timer_q;
    coin_rej_d = 1'b0;
    deny_d     = 1'b0;
    if (RST) begin
      case (CS)
        S_IDLE, S_COLLECT: begin
          if (CANCEL) begin
            ns_d       = (credit_q != 6'd0) ? S_CHANGE : S_IDLE;
            coin_rej_d = coin_present;
          end else if (coin_present) begin
            if (coin_sum <= CREDIT_MAX) begin
              credit_d = coin_sum[5:0];
              ns_d     = S_COLLECT;
            end else begin
              coin_rej_d = 1'b1;
              ns_d       = hold_s;
            end
          end else if (SEL_V) begin
            if (credit_q >= sel_price) begin
              ns_d     = S_VEND;
              credit_d = credit_q - sel_price;
              prod_d   = SEL;
              timer_d  = 2'd0;
            end else begin
              deny_d = 1'b1;
              ns_d   = hold_s;
            end
          end else begin
            ns_d = (credit_q != 6'd0) ? S_COLLECT : S_IDLE;
          end
        end
        S_VEND: begin
          coin_rej_d = coin_present;
          timer_d    = timer_q + 2'd1;
          if (timer_q < 2'd2) ns_d = S_VEND;
          else                ns_d = (credit_q != 6'd0) ? S_CHANGE : S_IDLE;
        end
        S_CHANGE: begin
          coin_rej_d = coin_present;
          if (credit_q != 6'd0) credit_d = credit_q - 6'd1;
          ns_d = (credit_q <= 6'd1) ? S_IDLE : S_CHANGE;
        end
        default: begin
          ns_d     = S_IDLE;
          credit_d = 6'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      credit_q   <= 6'd0;
      prod_q     <= 2'b00;
      timer_q    <= 2'd0;
      coin_rej_q <= 1'b0;
      deny_q     <= 1'b0;
    end else begin
      credit_q   <= credit_d;
      prod_q     <= prod_d;
      timer_q    <= timer_d;
      coin_rej_q <= coin_rej_d;
      deny_q     <= deny_d;
    end
  end

  assign NS         = ns_d;
  assign CREDIT     = credit_q;
  assign PROD       = prod_q;
  assign DISPENSE   = (CS == S_VEND);
  assign CHANGE_OUT = (CS == S_CHANGE) && (credit_q != 6'd0);
  assign COIN_REJ   = coin_rej_q;
  assign DENY       = deny_q;

endmodule

// File: tb/tb_vend_next_state.sv
// Directed bench for vend_next_state: models the external state memory (CS <= NS),
// queues hand-computed per-cycle expectations and checks them in a separate monitor.
module tb_vend_next_state;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cs;
  logic [3:0] cs_mem = 4'd0;
  logic       ovr = 1'b0;
  logic [3:0] ovr_cs = 4'd0;
  logic [1:0] coin = 2'b00, sel = 2'b00;
  logic       sel_v = 1'b0, cancel = 1'b0;
  logic [3:0] ns;
  logic [5:0] credit;
  logic [1:0] prod;
  logic       dispense, change_out, coin_rej, deny;

  typedef struct {
    int ns; int credit; int prod; int disp; int chg; int rej; int deny;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cs_mem <= ns;
  assign cs = ovr ? ovr_cs : cs_mem;

  vend_next_state dut (
    .CLK(clk), .RST(rst), .CS(cs), .COIN(coin), .SEL(sel), .SEL_V(sel_v),
    .CANCEL(cancel), .NS(ns), .CREDIT(credit), .PROD(prod), .DISPENSE(dispense),
    .CHANGE_OUT(change_out), .COIN_REJ(coin_rej), .DENY(deny)
  );

  function automatic exp_t E(int n, int cr, int pr, int di, int ch, int rj, int dn);
    exp_t e;
    e.ns = n; e.credit = cr; e.prod = pr; e.disp = di; e.chg = ch; e.rej = rj; e.deny = dn;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL cycle %0d %s: got %0d expected %0d", cyc, name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit [1:0] c, input bit [1:0] s, input bit sv,
                       input bit ca, input int ov, input exp_t e);
    @(posedge clk);
    #1;
    rst = r; coin = c; sel = s; sel_v = sv; cancel = ca;
    if (ov >= 0) begin
      ovr = 1'b1; ovr_cs = 4'(ov);
    end else begin
      ovr = 1'b0;
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      m_e = q.pop_front();
      cyc++;
      chk("NS",         int'(ns),         m_e.ns);
      chk("CREDIT",     int'(credit),     m_e.credit);
      chk("PROD",       int'(prod),       m_e.prod);
      chk("DISPENSE",   int'(dispense),   m_e.disp);
      chk("CHANGE_OUT", int'(change_out), m_e.chg);
      chk("COIN_REJ",   int'(coin_rej),   m_e.rej);
      chk("DENY",       int'(deny),       m_e.deny);
    end
  end

  initial begin
    // reset, with inputs active: NS forced to IDLE
    drive(0, 3, 0, 1, 0, -1, E(0, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, -1, E(0, 0, 0, 0, 0, 0, 0));
    // three 5-nickel coins, then buy product 1 (price 10), vend, change of 5
    drive(1, 3, 0, 0, 0, -1, E(1, 0, 0, 0, 0, 0, 0));
    drive(1, 3, 0, 0, 0, -1, E(1, 5, 0, 0, 0, 0, 0));
    drive(1, 3, 0, 0, 0, -1, E(1, 10, 0, 0, 0, 0, 0));
    drive(1, 0, 1, 1, 0, -1, E(2, 15, 0, 0, 0, 0, 0));
    drive(1, 1, 0, 0, 0, -1, E(2, 5, 1, 1, 0, 0, 0));
    drive(1, 0, 0, 0, 0, -1, E(2, 5, 1, 1, 0, 1, 0));
    drive(1, 0, 0, 1, 1, -1, E(3, 5, 1, 1, 0, 0, 0));
    for (int k = 5; k >= 2; k--) drive(1, 0, 0, 0, 0, -1, E(3, k, 1, 0, 1, 0, 0));
    drive(1, 0, 0, 0, 0, -1, E(0, 1, 1, 0, 1, 0, 0));
    drive(1, 0, 0, 0, 0, -1, E(0, 0, 1, 0, 0, 0, 0));
    // climb to 38, overflow reject, then exact 40 boundary
    for (int i = 0; i < 7; i++) drive(1, 3, 0, 0, 0, -1, E(1, 5 * i, 1, 0, 0, 0, 0));
    drive(1, 2, 0, 0, 0, -1, E(1, 35, 1, 0, 0, 0, 0));
    drive(1, 1, 0, 0, 0, -1, E(1, 37, 1, 0, 0, 0, 0));
    drive(1, 3, 0, 0, 0, -1, E(1, 38, 1, 0, 0, 0, 0));
    drive(1, 2, 0, 0, 0, -1, E(1, 38, 1, 0, 0, 1, 0));
    drive(1, 1, 0, 0, 0, -1, E(1, 40, 1, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, -1, E(0, 40, 1, 0, 0, 1, 0));
    drive(1, 0, 0, 0, 0, -1, E(0, 0, 0, 0, 0, 0, 0));
    // deny on low credit, coin beats select, cancel beats coin
    drive(1, 2, 0, 0, 0, -1, E(1, 0, 0, 0, 0, 0, 0));
    drive(1, 2, 0, 0, 0, -1, E(1, 2, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 1, 0, -1, E(1, 4, 0, 0, 0, 0, 0));
    drive(1, 1, 0, 1, 0, -1, E(1, 4, 0, 0, 0, 0, 1));
    drive(1, 2, 0, 0, 0, -1, E(1, 5, 0, 0, 0, 0, 0));
    drive(1, 2, 0, 1, 1, -1, E(3, 7, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, -1, E(3, 7, 0, 0, 1, 1, 0));
    for (int k = 6; k >= 2; k--) drive(1, 0, 0, 0, 0, -1, E(3, k, 0, 0, 1, 0, 0));
    drive(1, 0, 0, 0, 0, -1, E(0, 1, 0, 0, 1, 0, 0));
    drive(1, 0, 0, 0, 0, -1, E(0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 1, -1, E(0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, -1, E(0, 0, 0, 0, 0, 0, 0));
    // reset in second VEND cycle, then an illegal CS value
    drive(1, 3, 0, 0, 0, -1, E(1, 0, 0, 0, 0, 0, 0));
    drive(1, 3, 0, 0, 0, -1, E(1, 5, 0, 0, 0, 0, 0));
    drive(1, 3, 0, 0, 0, -1, E(1, 10, 0, 0, 0, 0, 0));
    drive(1, 0, 1, 1, 0, -1, E(2, 15, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, -1, E(2, 5, 1, 1, 0, 0, 0));
    drive(0, 0, 0, 0, 0, -1, E(0, 5, 1, 1, 0, 0, 0));
    drive(1, 0, 0, 0, 0, -1, E(0, 0, 0, 0, 0, 0, 0));
    drive(1, 3, 0, 0, 0, -1, E(1, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 10, E(0, 5, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, -1, E(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_next_state.md
VEND_NEXT_STATE -- requirements
Module: vend_next_state

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all registers update on rising edge.
REQ-002 SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port CS  input  4  current state returned from state memory (registered copy of NS, one cycle later).
REQ-004 SHALL have port COIN  input  2  coin this cycle: 00 none, 01 = 1 nickel, 10 = 2 nickels, 11 = 5 nickels.
REQ-005 SHALL have port SEL  input  2  product select: price 5/10/15/20 nickels for SEL 0/1/2/3.
REQ-006 SHALL have port SEL_V  input  1  select-valid strobe.
REQ-007 SHALL have port CANCEL  input  1  refund request.
REQ-008 SHALL have port NS  output  4  next state to state memory.
REQ-009 SHALL have port CREDIT  output  6  registered credit in nickels.
REQ-010 SHALL have port PROD  output  2  latched product of current vend.
REQ-011 SHALL have port DISPENSE  output  1  high while CS = VEND.
REQ-012 SHALL have port CHANGE_OUT  output  1  one nickel returned this cycle.
REQ-013 SHALL have port COIN_REJ  output  1  registered pulse, coin rejected previous cycle.
REQ-014 SHALL have port DENY  output  1  registered pulse, select refused previous cycle.

Function
REQ-015 SHALL encode states IDLE 0000, COLLECT 0001, VEND 0010, CHANGE 0011; NS combinational from CS, inputs, and internal registers.
REQ-016 SHALL, with CS any of 0100-1111, drive NS = IDLE and clear CREDIT at the next edge.
REQ-017 SHALL, in IDLE or COLLECT, resolve in priority CANCEL > COIN > SEL_V.
REQ-018 SHALL, on CANCEL with CREDIT > 0, drive NS = CHANGE; with CREDIT = 0, NS = IDLE; any coin that cycle is rejected.
REQ-019 SHALL accept a coin only if CREDIT + value <= 40; accepted coin adds at the edge and NS = COLLECT.
REQ-020 SHALL reject an overflowing coin: CREDIT unchanged, COIN_REJ = 1 next cycle, NS unchanged from CS.
REQ-021 SHALL ignore SEL_V (no DENY) in a cycle where a coin is present, accepted or not.
REQ-022 SHALL, on SEL_V with CREDIT >= price, drive NS = VEND; at the edge subtract price, latch PROD = SEL, clear vend timer.
REQ-023 SHALL, on SEL_V with CREDIT < price, keep NS equal to CS and pulse DENY next cycle.
REQ-024 SHALL drive NS = COLLECT in IDLE/COLLECT when CREDIT > 0 and no other event, NS = IDLE when CREDIT = 0.
REQ-025 SHALL stay in VEND for exactly 3 cycles: 2-bit timer increments each VEND cycle; NS = VEND while timer < 2.
REQ-026 SHALL, at timer = 2, drive NS = CHANGE if CREDIT > 0 else IDLE.
REQ-027 SHALL reject all coins (COIN_REJ) and ignore SEL_V and CANCEL while CS = VEND or CHANGE.
REQ-028 SHALL, while CS = CHANGE and CREDIT > 0, assert CHANGE_OUT and decrement CREDIT by 1 per cycle.
REQ-029 SHALL drive NS = IDLE from CHANGE when CREDIT <= 1; CHANGE with CREDIT = 0 gives no CHANGE_OUT.
REQ-030 SHALL drive DISPENSE and CHANGE_OUT combinationally from CS and CREDIT; COIN_REJ and DENY are registered one-cycle pulses.

Reset
REQ-031 SHALL, on a rising edge with RST = 0, set CREDIT = 0, PROD = 00, vend timer = 0, COIN_REJ = 0, DENY = 0.
REQ-032 SHALL force NS = 0000 while RST = 0 regardless of CS or inputs.
REQ-033 SHALL, on reset mid-vend or mid-change, abandon the operation; credit is lost, no further CHANGE_OUT.

Verification
REQ-034 SHALL be checked: from IDLE, COIN = 11,11,11 -> CREDIT 5,10,15, NS = COLLECT.
REQ-035 SHALL be checked: CREDIT 15, SEL = 1, SEL_V -> NS = VEND, CREDIT 5, PROD 01, DISPENSE 3 cycles, then 5 CHANGE_OUT cycles, then IDLE, CREDIT 0.
REQ-036 SHALL be checked: CREDIT 38, COIN = 11 -> COIN_REJ next cycle, CREDIT stays 38; then COIN = 10 accepted -> 40.
REQ-037 SHALL be checked: CREDIT 4, SEL = 0, SEL_V -> DENY next cycle, CREDIT 4, NS = COLLECT; same cycle with COIN = 01 -> CREDIT 5, no DENY.
REQ-038 SHALL be checked: CREDIT 7, CANCEL with COIN = 10 -> COIN_REJ, NS = CHANGE, 7 CHANGE_OUT pulses, then IDLE.
REQ-039 SHALL be checked: RST = 0 in second VEND cycle -> NS = 0000, CREDIT 0 at next edge; CS = 1010 -> NS = IDLE.
